uart_tx_fifo: RTL and testbench

- Synthesizable 8N1 UART transmitter with a small input FIFO.
- Driven by the SoC peripheral bus side; output pin feeds the board UART and the simulation UART listener.
- Transmits each queued byte as start bit (0), 8 data bits LSB first, then stop bit (1).
- Back-to-back frames are sent with no idle gap.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// Frames are sent back to back straight from the stop bit when more data is queued.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] DAT_I,
  input  logic       STB_I,
  output logic       RDY_O,
  output logic       TX_O,
  output logic       BUSY_O
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              tx;
  logic              push;
  logic              pop;
  logic              baud_done;
  logic              fifo_empty;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign fifo_empty = (count == '0);
  assign RDY_O      = (count != FULL_CNT);
  assign push       = STB_I && RDY_O;
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign TX_O       = tx;
  assign BUSY_O     = (state != IDLE) || !fifo_empty;

  always_ff @(posedge CLK_I) begin
    if (push) begin
      mem[wr_ptr] <= DAT_I;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!fifo_empty) state_next = START;
      START: if (baud_done) state_next = DATA;
      DATA:  if (baud_done && bit_cnt == 3'd7) state_next = STOP;
      STOP:  if (baud_done) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      pop = (state == IDLE) || (state == STOP && baud_done);
    end
  end

  // Datapath: the line level for the next bit is registered on the same edge the FSM moves.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else if (pop) begin
      shift    <= mem[rd_ptr];
      tx       <= 1'b0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
        START: begin
          if (baud_done) begin
            tx       <= shift[0];
            bit_cnt  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            shift    <= shift >> 1;
            bit_cnt  <= bit_cnt + 1'b1;
            baud_cnt <= '0;
            tx       <= (bit_cnt == 3'd7) ? 1'b1 : shift[1];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line listener decodes frames against a scoreboard of accepted bytes.
// A second instance with two clocks per bit is checked bit-exactly.
module tb_uart_tx_fifo;

  localparam int CPB = 16;
  localparam int MID = CPB / 2 - 1;

  logic       clk;
  logic       rst_n;
  logic [7:0] dat;
  logic [7:0] dat2;
  logic       stb;
  logic       stb2;
  logic       rdy;
  logic       rdy2;
  logic       tx;
  logic       tx2;
  logic       busy;
  logic       busy2;

  int         n_vectors     = 0;
  int         n_miscompares = 0;
  int         frames_seen   = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) u_dut (
    .CLK_I (clk),
    .RST_I (rst_n),
    .DAT_I (dat),
    .STB_I (stb),
    .RDY_O (rdy),
    .TX_O  (tx),
    .BUSY_O(busy)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut2 (
    .CLK_I (clk),
    .RST_I (rst_n),
    .DAT_I (dat2),
    .STB_I (stb2),
    .RDY_O (rdy2),
    .TX_O  (tx2),
    .BUSY_O(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Holds the strobe until the byte is taken; the accepting edge queues it for the listener.
  task automatic write_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    stb = 1'b1;
    dat = b;
    while (!rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      check_output("write_accept", {31'd0, rdy}, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, {31'd0, busy}, 32'd0);
  endtask

  // Line listener: samples mid-bit on falling clock edges and pops the scoreboard per frame.
  initial begin : listener
    bit         active = 1'b0;
    int         cnt = 0;
    int         b;
    logic [7:0] rx_byte = '0;
    logic [31:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt % CPB == MID) begin
          b = cnt / CPB;
          if (b == 0) begin
            check_output("start_bit", {31'd0, tx}, 32'd0);
          end else if (b <= 8) begin
            rx_byte = {tx, rx_byte[7:1]};
          end else begin
            check_output("stop_bit", {31'd0, tx}, 32'd1);
            exp_v = (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD_0000;
            check_output("rx_byte", {24'd0, rx_byte}, exp_v);
            frames_seen++;
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int         j;
    int         errs;
    int         n;
    int         f0;
    logic [9:0] frame;

    rst_n = 1'b1;
    stb   = 1'b0;
    stb2  = 1'b0;
    dat   = '0;
    dat2  = '0;
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_tx", {31'd0, tx}, 32'd1);
    check_output("reset_rdy", {31'd0, rdy}, 32'd1);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_tx2", {31'd0, tx2}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single frame 0x55");
    frame = {1'b1, 8'h55, 1'b0};
    write_byte(8'h55);
    @(negedge clk);
    stb = 1'b0;
    check_output("t1_pre_pop_tx", {31'd0, tx}, 32'd1);
    check_output("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_output("t1_tx_fall", {31'd0, tx}, 32'd0);
    j = 0;
    errs = 0;
    while (busy && j < 400) begin
      if (j < 10 * CPB && tx !== frame[j / CPB]) errs++;
      @(negedge clk);
      j++;
    end
    check_output("t1_levels", errs, 0);
    check_output("t1_busy_len", j, 10 * CPB);

    $display("[TB] back to back A3 00 FF");
    f0 = frames_seen;
    write_byte(8'hA3);
    write_byte(8'h00);
    write_byte(8'hFF);
    @(negedge clk);
    stb = 1'b0;
    check_output("t2_start", {31'd0, tx}, 32'd0);
    j = 1;
    while (busy && j < 1000) begin
      @(negedge clk);
      j++;
    end
    check_output("t2_busy_len", j, 30 * CPB);
    repeat (2) @(negedge clk);
    check_output("t2_frames", frames_seen - f0, 3);
    check_output("t2_sb_empty", exp_q.size(), 0);

    $display("[TB] overfill with 0x10..0x15");
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("t3_rdy", {31'd0, rdy}, (i < 5) ? 32'd1 : 32'd0);
      stb = 1'b1;
      dat = 8'h10 + 8'(i);
      @(posedge clk);
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    stb = 1'b0;
    check_output("t3_rdy_full", {31'd0, rdy}, 32'd0);
    wait_idle("t3_idle", 1200);
    repeat (2) @(negedge clk);
    check_output("t3_frames", frames_seen - f0, 5);
    check_output("t3_sb_empty", exp_q.size(), 0);

    $display("[TB] reset mid-frame");
    frame = {1'b1, 8'h0F, 1'b0};
    write_byte(8'h0F);
    write_byte(8'h01);
    write_byte(8'h02);
    @(negedge clk);
    stb = 1'b0;
    repeat (71) @(negedge clk);
    check_output("t4_bit3", {31'd0, tx}, {31'd0, frame[4]});
    check_output("t4_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_output("t4_tx_async", {31'd0, tx}, 32'd1);
    check_output("t4_busy_async", {31'd0, busy}, 32'd0);
    check_output("t4_rdy_async", {31'd0, rdy}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    f0 = frames_seen;
    errs = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check_output("t4_idle_after", errs, 0);
    check_output("t4_frames", frames_seen - f0, 0);

    $display("[TB] held strobe across full-FIFO pop");
    f0 = frames_seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stb = 1'b1;
      dat = 8'h20 + 8'(i);
      @(posedge clk);
      exp_q.push_back(8'h20 + 8'(i));
    end
    @(negedge clk);
    dat = 8'h25;
    n = 0;
    while (!rdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_output("t5_wait", n, 10 * CPB - 3);
    check_output("t5_pop_start", {31'd0, tx}, 32'd0);
    @(posedge clk);
    exp_q.push_back(8'h25);
    @(negedge clk);
    stb = 1'b0;
    check_output("t5_refull", {31'd0, rdy}, 32'd0);
    wait_idle("t5_idle", 1300);
    repeat (2) @(negedge clk);
    check_output("t5_frames", frames_seen - f0, 6);
    check_output("t5_sb_empty", exp_q.size(), 0);

    $display("[TB] two clocks per bit, 0x81");
    frame = {1'b1, 8'h81, 1'b0};
    @(negedge clk);
    stb2 = 1'b1;
    dat2 = 8'h81;
    @(posedge clk);
    @(negedge clk);
    stb2 = 1'b0;
    check_output("t6_pre_pop_tx", {31'd0, tx2}, 32'd1);
    @(negedge clk);
    check_output("t6_tx_fall", {31'd0, tx2}, 32'd0);
    j = 0;
    errs = 0;
    while (busy2 && j < 100) begin
      if (j < 20 && tx2 !== frame[j / 2]) errs++;
      @(negedge clk);
      j++;
    end
    check_output("t6_levels", errs, 0);
    check_output("t6_busy_len", j, 20);
    check_output("t6_tx_idle", {31'd0, tx2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
